// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: accepts one read or write, stalls the
// pipeline for LATENCY cycles, then pulses done. Words 0 and 1 are mirrored on out1/out2.
module data_mem_responder #(
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = 6,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] adr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] out1,
    output logic [31:0] out2
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [31:0]          mem [DEPTH];
    logic                 req;
    logic                 illegal;
    logic                 accept;
    logic                 access;
    logic                 do_read;
    logic                 do_write;
    logic [ADDR_BITS-1:0] idx;
    logic                 unused_adr_bits;

    // Upper address bits are dropped on purpose so addresses wrap modulo DEPTH*4.
    assign idx             = adr[ADDR_BITS+1:2];
    assign unused_adr_bits = ^adr[31:ADDR_BITS+2];

    assign req     = mem_read ^ mem_write;
    assign illegal = (mem_read & mem_write) | (req & (adr[1:0] != 2'b00));
    assign done    = (state == DONE);
    assign stall   = req & ~illegal & ~done;
    assign accept  = (state == IDLE) & req & ~illegal;

    // The operation is taken from whatever is on the bus at the access edge.
    assign do_read  = access & mem_read & ~mem_write;
    assign do_write = access & mem_write & ~mem_read;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves one unassigned and infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        access    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = DONE;
                        access    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                    access    = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err   <= (state == IDLE) & illegal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the array is reset word by word because a reset must leave the memory all-zero; this forces flops, not RAM macros.
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            mem[idx] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
        end else if (do_read) begin
            read_data <= mem[idx];
        end
    end

    // Registered mirrors: a committed write shows up here one cycle after the commit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out1 <= '0;
            out2 <= '0;
        end else begin
            out1 <= mem[0];
            out2 <= mem[1];
        end
    end

endmodule
